// File: rtl/piso_right_tx.sv
// piso_right_tx
//   Parallel-in / serial-out transmitter. A DW-bit word is accepted with a
//   valid/ready handshake and shifted out LSB first, one bit per enb-qualified
//   clock edge. A one-cycle DONE state closes each frame and pulses done_o.
//
//   Optional feature: define PISO_TX_PARITY_EN to append one even-parity bit
//   (XOR of the loaded word) after the data bits, held for one enb-qualified
//   bit period.
//
// Parameters
//   DW       payload width in bits (2..32)
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   enb      bit strobe; the serial state only advances when enb=1
//   data_i   parallel word, sampled only at the handshake edge
//   valid_i  data_i is valid
//   ready_o  block is idle and can accept a word
//   out      serial output, LSB first, 0 when not shifting
//   busy_o   a frame is in progress (SHIFT, PARITY or DONE)
//   done_o   one-cycle frame-complete pulse

module piso_right_tx #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          out,
  output logic          busy_o,
  output logic          done_o
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q,   cnt_d;
`ifdef PISO_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  // State, shift register and bit counter. Reset returns to an empty IDLE,
  // which also forces out to 0 since out is decoded from the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and output decode. Everything holds unless a handshake
  // happens in IDLE or enb qualifies an edge in SHIFT/PARITY; DONE always
  // lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    out     = 1'b0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          shift_d = data_i;
          cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
          // Parity is captured from the loaded word, since the shift
          // register is consumed as the frame goes out.
          parity_d = ^data_i;
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        busy_o = 1'b1;
        out    = shift_q[0];
        if (enb) begin
          shift_d = {1'b0, shift_q[DW-1:1]};
          // The counter stops at the last bit index instead of wrapping.
          if (cnt_q == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        busy_o = 1'b1;
        out    = parity_q;
        if (enb) begin
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_right_tx.sv
// tb_piso_right_tx
//   Directed testbench for piso_right_tx with DW=4. Inputs are driven and
//   outputs sampled on the falling edge, so every check sees the state that
//   the preceding rising edge produced. Expected outputs are packed as
//   {ready_o, busy_o, done_o, out}.

module tb_piso_right_tx;

  logic       clk;
  logic       rst;
  logic       enb;
  logic [3:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       out;
  logic       busy_o;
  logic       done_o;

  int checks;
  int errors;

  localparam logic [3:0] IDL = 4'b1000;
  localparam logic [3:0] SH0 = 4'b0100;
  localparam logic [3:0] SH1 = 4'b0101;
  localparam logic [3:0] DN  = 4'b0110;

  piso_right_tx #(.DW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enb     (enb),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .out     (out),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set up the inputs that the next rising edge will see.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic e);
    valid_i = v;
    data_i  = d;
    enb     = e;
  endtask

  // Compare the packed output vector against the hand-computed value.
  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {ready_o, busy_o, done_o, out};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b (ready,busy,done,out)",
             tag, observed, expected);
    end
  endtask

  // Advance one full cycle, landing on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] slow_bits;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0);
    $display("[TB] starting piso_right_tx directed test");

    // Reset asserted and released.
    #2 rst = 1'b0;
    #1 checkOutput("reset_hold", IDL);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("reset_release", IDL);

    // 4'b1011 with enb=1: out 1,1,0,1 then DONE then IDLE.
    applyStimulus(1'b1, 4'b1011, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("f1_bit0", SH1); tick();
    checkOutput("f1_bit1", SH1); tick();
    checkOutput("f1_bit2", SH0); tick();
    checkOutput("f1_bit3", SH1); tick();
`ifdef PISO_TX_PARITY_EN
    checkOutput("f1_parity", SH1); tick();
`endif
    checkOutput("f1_done", DN); tick();
    checkOutput("f1_idle", IDL);

    // 4'b0110 with enb toggling 0,1,...: each bit held two cycles.
    slow_bits = 8'b0011_1100;
    applyStimulus(1'b1, 4'b0110, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'h0, (i % 2) == 1);
      checkOutput($sformatf("slow_bit%0d", i), {3'b010, slow_bits[i]});
      tick();
    end
`ifdef PISO_TX_PARITY_EN
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("slow_par_a", SH0); tick();
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("slow_par_b", SH0); tick();
`endif
    // DONE must end after one cycle even with enb low.
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("slow_done", DN); tick();
    checkOutput("slow_idle", IDL);

    // 4'h1 frame with valid_i/4'hF offered mid-frame: ignored.
    applyStimulus(1'b1, 4'h1, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("ign_bit0", SH1); tick();
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("ign_bit1", SH0); tick();
    checkOutput("ign_bit2", SH0); tick();
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("ign_bit3", SH0); tick();
`ifdef PISO_TX_PARITY_EN
    checkOutput("ign_parity", SH1); tick();
`endif
    checkOutput("ign_done", DN); tick();
    checkOutput("ign_idle", IDL); tick();
    checkOutput("ign_still_idle", IDL);

    // Reset pulsed in cycle 2 of a frame: immediate IDLE, no done_o.
    applyStimulus(1'b1, 4'b1011, 1'b1);
    tick();
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("abort_bit0", SH1); tick();
    checkOutput("abort_bit1", SH1);
    #1 rst = 1'b0;
    #1 checkOutput("abort_async", IDL);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort_release", IDL); tick();
    checkOutput("abort_no_done", IDL); tick();
    checkOutput("abort_no_done2", IDL);

    // valid_i held high: 4'h3 then 4'hC back to back.
    applyStimulus(1'b1, 4'h3, 1'b1);
    tick();
    applyStimulus(1'b1, 4'hC, 1'b1);
    checkOutput("b2b_a_bit0", SH1); tick();
    checkOutput("b2b_a_bit1", SH1); tick();
    checkOutput("b2b_a_bit2", SH0); tick();
    checkOutput("b2b_a_bit3", SH0); tick();
`ifdef PISO_TX_PARITY_EN
    checkOutput("b2b_a_parity", SH0); tick();
`endif
    checkOutput("b2b_a_done", DN); tick();
    checkOutput("b2b_gap_idle", IDL); tick();
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("b2b_b_bit0", SH0); tick();
    checkOutput("b2b_b_bit1", SH0); tick();
    checkOutput("b2b_b_bit2", SH1); tick();
    checkOutput("b2b_b_bit3", SH1); tick();
`ifdef PISO_TX_PARITY_EN
    checkOutput("b2b_b_parity", SH0); tick();
`endif
    checkOutput("b2b_b_done", DN); tick();
    checkOutput("b2b_b_idle", IDL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_right_tx.md
PISO_RIGHT_TX -- requirements
Module: piso_right_tx

Interface
REQ-001 The block SHALL have parameter DW, default 4, giving the payload width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enb, input, 1 bit: bit-strobe; the serial state advances only on clk edges where enb=1.
REQ-005 The block SHALL have port data_i, input, DW bits: the parallel word to transmit.
REQ-006 The block SHALL have port valid_i, input, 1 bit: data_i is valid.
REQ-007 The block SHALL have port ready_o, output, 1 bit: the block can accept a word.
REQ-008 The block SHALL have port out, output, 1 bit: the serial bit stream, LSB first.
REQ-009 The block SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port done_o, output, 1 bit: a one-cycle frame-complete pulse.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT, PARITY (present only with the macro) and DONE.
REQ-012 In IDLE the block SHALL drive ready_o=1, busy_o=0, done_o=0 and out=0.
REQ-013 A handshake SHALL occur on a clk edge with valid_i=1 and ready_o=1, independent of enb; data_i SHALL be loaded into a DW-bit shift register, the bit counter SHALL clear to 0, and the FSM SHALL enter SHIFT.
REQ-014 In SHIFT the block SHALL drive out=shift_reg[0], busy_o=1 and ready_o=0; the first bit SHALL appear in the cycle after the handshake edge.
REQ-015 On each SHIFT edge with enb=1, the register SHALL shift right with 0 filled at the MSB, and the counter SHALL increment.
REQ-016 On the enb=1 edge where counter==DW-1, the FSM SHALL leave SHIFT for PARITY (macro defined) or DONE (macro undefined).
REQ-017 While enb=0, the state, the counter, the shift register and out SHALL all hold.
REQ-018 The DONE state SHALL last exactly one clk cycle regardless of enb, with done_o=1, busy_o=1, ready_o=0 and out=0; the FSM SHALL then return to IDLE.
REQ-019 valid_i SHALL be ignored while ready_o=0; there is no input buffering, and data_i is sampled only at the handshake.
REQ-020 Minimum handshake-to-handshake spacing SHALL be DW+2 cycles (DW+3 with parity) when enb is held at 1.
REQ-021 The counter SHALL be $clog2(DW) bits wide and SHALL never wrap within a frame.

Reset
REQ-022 While rst=0, the block SHALL force state=IDLE, shift register=0, counter=0 and out=0, asynchronously.
REQ-023 In reset and on the first cycle after rst deasserts, outputs SHALL be ready_o=1, busy_o=0, done_o=0 and out=0.
REQ-024 A reset asserted mid-frame SHALL abort the frame with no done_o pulse.

Configuration
REQ-025 When macro PISO_TX_PARITY_EN is defined, the PARITY state SHALL drive out=even parity (XOR of the loaded data_i) for one enb-qualified bit period, then move to DONE.
REQ-026 When PISO_TX_PARITY_EN is undefined, the PARITY state and the parity logic SHALL be absent, and the frame SHALL be DW bits.

Verification
REQ-027 DW=4, no macro, enb=1, accept 4'b1011 at edge 0 -> out=1,1,0,1 in cycles 1-4, done_o=1 in cycle 5, ready_o=1 in cycle 6.
REQ-028 PISO_TX_PARITY_EN defined, accept 4'b1011 with enb=1 -> out=1,1,0,1 then parity bit 1 in cycle 5, done_o in cycle 6.
REQ-029 enb toggling 1,0,1,0..., accept 4'b0110 -> each bit held for 2 cycles: out=0,0,1,1,1,1,0,0, then done_o.
REQ-030 valid_i=1 with data 4'hF during cycles 2-3 of a 4'h1 frame -> data ignored, out stays 1,0,0,0, and the next frame starts only after IDLE.
REQ-031 rst pulsed low in cycle 2 of a frame -> out=0 and ready_o=1 immediately, with no done_o pulse.
REQ-032 valid_i held at 1 with words 4'h3 then 4'hC -> two complete frames separated by exactly one DONE and one IDLE cycle.
